mesh_out_arbiter: RTL
=====================

Name: mesh_out_arbiter

Overview:
- Round-robin arbiter for one mesh router output port. It shares the output between NUM_IN input FIFOs that use the pndng/pop handshake, and forwards the winning packet into a one-entry output register.
- The output side presents the same pndng/data/pop handshake to the downstream consumer (the next router or a terminal popin/data_out_i_in path).
- One instance is placed per output direction per router in the ROWS x COLUMNS mesh.

Parameters:
- NUM_IN, 4, number of requesting input FIFOs (2..16).
- pkg_sz, 40, packet width in bits.
- CNT_W, 16, grant counter width; used only with MESH_ARB_CNT_EN.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_pndng  input  NUM_IN  bit i high = input FIFO i has a head packet.
- in_data  input  NUM_IN*pkg_sz  head packets; slice i is bits [i*pkg_sz +: pkg_sz].
- in_pop  output  NUM_IN  one-hot or zero; pops head of FIFO i at the same clock edge.
- out_pndng  output  1  output register holds a valid packet.
- out_data  output  pkg_sz  packet held in the output register.
- out_pop  input  1  downstream consumes out_data at this edge.
- grant_id  output  $clog2(NUM_IN)  index of the most recent grant.
- grant_cnt  output  NUM_IN*CNT_W  per-input grant counters; present only with MESH_ARB_CNT_EN.

Behaviour:
- Reset is asynchronous and active-high. During reset:
  - out_pndng=0, out_data=0, grant_id=NUM_IN-1 (so input 0 has first priority).
  - in_pop=0 combinationally while reset is high.
  - grant_cnt=0.
- Slot free condition: slot_free = !out_pndng || out_pop.
- Arbitration (combinational):
  - When slot_free and |in_pndng, pick winner w = the first i with in_pndng[i]=1, searching (grant_id+1) mod NUM_IN upward with wrap-around.
  - in_pop = one-hot(w); in_pop is never asserted unless in_pndng[w]=1.
- At the clock edge, when a grant occurs:
  - out_data <= in_data[w], out_pndng <= 1, grant_id <= w.
- Pass-through case (out_pop=1 with a grant in the same cycle): the new packet replaces the consumed one, out_pndng stays 1. Sustained throughput is 1 packet/cycle.
- out_pop=1 with no grant: out_pndng <= 0. out_data holds its last value (don't-care to consumers).
- out_pop while out_pndng=0: ignored, no state change.
- Output full and out_pop=0: in_pop=0 and all state holds (back-pressure).
- Latency: in_pndng rising to out_pndng high is 1 cycle when the slot is free.
- Fairness: with all inputs pending continuously, grants rotate 0,1,...,NUM_IN-1,0,... No input waits more than NUM_IN-1 grants.
- Single requester: it is granted every cycle the slot is free.
- Arbiter states:
  - EMPTY (out_pndng=0): goes to FULL on a grant.
  - FULL (out_pndng=1): stays in FULL on pop+grant or on no pop; goes to EMPTY on pop with no grant.
- Reset mid-transfer: the packet held in the output register is discarded. Input FIFOs are not popped in the reset cycle.
- Invariants (assertion-checked):
  - $onehot0(in_pop).
  - (in_pop & ~in_pndng)==0.
  - in_pop==0 whenever out_pndng && !out_pop.

Optional Feature:
- Macro: MESH_ARB_CNT_EN.
- Defined:
  - grant_cnt port exists; counter i increments on each edge where in_pop[i]=1.
  - Counters saturate at 2^CNT_W-1 and clear on reset.
- Undefined:
  - Port and counters are absent; arbitration behaviour is identical.

Decomposition:
- Package mesh_arb_pkg holds:
  - function rr_pick(req, last) returning the winner index and a valid flag.
  - localparam default values for pkg_sz and NUM_IN.
- Sub-module rr_arbiter (NUM_IN): pure combinational priority rotation with inputs req and last and outputs gnt_onehot and gnt_idx.
- mesh_out_arbiter contains the output register, state, grant_id and the optional counters.

Test Plan:
1. Reset, then in_pndng=4'b0001, in_data[0]=40'hA5_0000_0001, out_pop=0 -> next cycle out_pndng=1 with that data. in_pop[0] was high for exactly 1 cycle, and stays 0 afterwards while out_pop=0.
2. All four inputs pending continuously, out_pop=1 every cycle -> grant_id sequence 0,1,2,3,0,1. One pop per cycle, out_pndng held at 1.
3. in_pndng=4'b1010 after grant_id=3 -> input 1 is granted first, then input 3 (wrap-around skipping idle inputs).
4. Output full, out_pop=0 for 5 cycles with all inputs pending -> in_pop=0 and out_data stable. Then out_pop=1 for one cycle -> exactly one new grant in that same cycle.
5. Assert reset while out_pndng=1 and inputs pending -> out_pndng=0 and in_pop=0 immediately. After release, input 0 is granted first.
6. With MESH_ARB_CNT_EN and CNT_W=4: 20 grants to input 2 -> grant_cnt[2] saturates at 15, other counters remain 0.

Source files
------------

// File: rtl/mesh_arb_pkg.sv
// Shared types, default sizes and the round-robin pick function for the mesh output arbiter.
// Latency: n/a (package). Backpressure: n/a.
// Optional MESH_ARB_CNT_EN (used by mesh_out_arbiter) adds per-input grant counters.
package mesh_arb_pkg;

    localparam int PKG_SZ_DEF = 40;
    localparam int NUM_IN_DEF = 4;
    localparam int MAX_IN     = 16;
    localparam int MAX_IDX_W  = 4;

    // Output-register occupancy; EMPTY maps directly onto out_pndng=0.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                 vld;
        logic [MAX_IDX_W-1:0] idx;
    } pick_t;

    // First requester found scanning upward from last+1, wrapping at n.
    function automatic pick_t rr_pick(input logic [MAX_IN-1:0]    req,
                                      input logic [MAX_IDX_W-1:0] last,
                                      input int unsigned          n);
        pick_t       p;
        int unsigned j;
        p = '0;
        for (int unsigned k = 1; k <= MAX_IN; k++) begin
            if (k <= n) begin
                j = (int'(last) + k) % n;
                if (!p.vld && req[j]) begin
                    p.vld = 1'b1;
                    p.idx = MAX_IDX_W'(j);
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mesh_out_arbiter_rr.sv
// Combinational round-robin priority rotation over NUM_IN requests.
// Latency: 0 cycles (pure combinational).
// Backpressure: none here; the caller gates the grant with its slot-free condition.
module rr_arbiter
    import mesh_arb_pkg::*;
#(
    parameter int NUM_IN = NUM_IN_DEF
) (
    input  logic [NUM_IN-1:0]         req,
    input  logic [$clog2(NUM_IN)-1:0] last,
    output logic [NUM_IN-1:0]         gnt_onehot,
    output logic [$clog2(NUM_IN)-1:0] gnt_idx,
    output logic                      gnt_vld
);

    localparam int IDX_W = $clog2(NUM_IN);

    logic [MAX_IN-1:0]    req_ext;
    logic [MAX_IDX_W-1:0] last_ext;
    pick_t                pick;
    logic                 unused_idx_hi;

    // Widen to the package's fixed search width, then pick the winner.
    always_comb begin
        req_ext                = '0;
        req_ext[NUM_IN-1:0]    = req;
        last_ext               = '0;
        last_ext[IDX_W-1:0]    = last;
        pick                   = rr_pick(req_ext, last_ext, NUM_IN);
    end

    // Upper index bits are always zero for NUM_IN below the maximum.
    assign unused_idx_hi = ^pick.idx;

    assign gnt_vld = pick.vld;
    assign gnt_idx = pick.idx[IDX_W-1:0];

    // Decode the winner index into a one-hot grant vector.
    always_comb begin
        gnt_onehot = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (pick.vld && (gnt_idx == IDX_W'(i))) gnt_onehot[i] = 1'b1;
        end
    end

endmodule

// File: rtl/mesh_out_arbiter.sv
// Round-robin arbiter for one mesh router output port feeding a one-entry output register.
// Latency: 1 cycle from in_pndng to out_pndng when the slot is free; 1 packet/cycle sustained.
// Backpressure: output full and no out_pop -> no in_pop, all state holds. MESH_ARB_CNT_EN adds grant_cnt.
module mesh_out_arbiter
    import mesh_arb_pkg::*;
#(
    parameter int NUM_IN = NUM_IN_DEF,
    parameter int pkg_sz = PKG_SZ_DEF,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_IN-1:0]          in_pndng,
    input  logic [NUM_IN*pkg_sz-1:0]   in_data,
    output logic [NUM_IN-1:0]          in_pop,
    output logic                       out_pndng,
    output logic [pkg_sz-1:0]          out_data,
    input  logic                       out_pop,
    output logic [$clog2(NUM_IN)-1:0]  grant_id
`ifdef MESH_ARB_CNT_EN
    ,
    output logic [NUM_IN*CNT_W-1:0]    grant_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_IN);

    arb_state_e                      state_q;
    logic [pkg_sz-1:0]               data_q;
    logic [IDX_W-1:0]                gid_q;

    logic [NUM_IN-1:0][pkg_sz-1:0]   in_arr;
    logic [NUM_IN-1:0]               gnt_onehot;
    logic [IDX_W-1:0]                gnt_idx;
    logic                            gnt_vld;
    logic                            slot_free;
    logic                            grant;

    assign in_arr = in_data;

    rr_arbiter #(
        .NUM_IN (NUM_IN)
    ) u_rr (
        .req        (in_pndng),
        .last       (gid_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .gnt_vld    (gnt_vld)
    );

    // A grant may only land when the register is empty or drains this edge.
    always_comb begin
        slot_free = (state_q == ST_EMPTY) || out_pop;
        grant     = slot_free && gnt_vld && !reset;
        in_pop    = grant ? gnt_onehot : '0;
    end

    // Output register FSM: EMPTY fills on grant; FULL refills on grant or empties on a bare pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            gid_q   <= IDX_W'(NUM_IN - 1);
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (grant) begin
                        state_q <= ST_FULL;
                        data_q  <= in_arr[gnt_idx];
                        gid_q   <= gnt_idx;
                    end
                end
                ST_FULL: begin
                    if (grant) begin
                        data_q  <= in_arr[gnt_idx];
                        gid_q   <= gnt_idx;
                    end else if (out_pop) begin
                        state_q <= ST_EMPTY;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    assign out_pndng = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign grant_id  = gid_q;

`ifdef MESH_ARB_CNT_EN
    logic [NUM_IN-1:0][CNT_W-1:0] cnt_q;

    // Per-input grant counters, saturating at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (in_pop[i] && (cnt_q[i] != {CNT_W{1'b1}})) cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

    assign grant_cnt = cnt_q;
`endif

`ifndef SYNTHESIS
    a_pop_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(in_pop));
    a_pop_pndng:   assert property (@(posedge clk) disable iff (reset) (in_pop & ~in_pndng) == '0);
    a_pop_bp:      assert property (@(posedge clk) disable iff (reset)
                                    (out_pndng && !out_pop) |-> (in_pop == '0));
`endif

endmodule
